// File: rtl/ttuart_rx_fifo.sv
// UART receive FIFO: turns the receiver's level-style byte-ready into one push per
// byte, buffers bytes first-word fall-through, and tracks fill level plus sticky overflow.
module ttuart_rx_fifo #(
  parameter  int DEPTH = 8,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_data_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LVL_W-1:0] fifo_level,
  output logic             overflow,
  input  logic             clear_overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic             rdy_q, rdy_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             overflow_q, overflow_d;

  logic [7:0]       mem [DEPTH];

  logic             push;
  logic             pop;
  logic             full;
  logic             wr_en;

  always_comb begin
    push  = rx_data_ready & ~rdy_q;
    pop   = (level_q != '0) & out_ready;
    full  = (level_q == LVL_W'(DEPTH));
    // A full FIFO still takes the byte when the head leaves in the same cycle.
    wr_en = push & (~full | pop);

    rdy_d    = rx_data_ready;
    wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    level_d = level_q;
    if (wr_en && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop && !wr_en) begin
      level_d = level_q - LVL_W'(1);
    end

    overflow_d = overflow_q;
    if (push && full && !pop) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rdy_q      <= rdy_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage carries no reset so it can map onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= rx_data;
    end
  end

  always_comb begin
    out_valid  = (level_q != '0);
    out_data   = out_valid ? mem[rd_ptr_q] : 8'h00;
    fifo_level = level_q;
    overflow   = overflow_q;
  end

endmodule

// File: tb/tb_ttuart_rx_fifo.sv
// Directed bench for ttuart_rx_fifo: expected bytes queued at push time,
// compared in order as the FIFO presents them.
module tb_ttuart_rx_fifo;

  localparam int DEPTH = 8;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       rx_data;
  logic             rx_data_ready;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic [LVL_W-1:0] fifo_level;
  logic             overflow;
  logic             clear_overflow;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  ttuart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_data        (rx_data),
    .rx_data_ready  (rx_data_ready),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit accepted);
    rx_data       = b;
    rx_data_ready = 1'b1;
    step();
    rx_data_ready = 1'b0;
    if (accepted) exp_q.push_back(b);
    step();
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, 32'(out_data), 32'(e));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) pop_check(tag);
    check({tag, "_empty_level"}, 32'(fifo_level), 32'd0);
    check({tag, "_empty_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    rx_data        = 8'h00;
    rx_data_ready  = 1'b0;
    out_ready      = 1'b0;
    clear_overflow = 1'b0;
    step();
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'h00);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    step();

    // Empty FIFO ignores out_ready.
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("empty_pop_level", 32'(fifo_level), 32'd0);

    // 1: single byte, one-cycle latency.
    rx_data       = 8'hA5;
    rx_data_ready = 1'b1;
    step();
    rx_data_ready = 1'b0;
    exp_q.push_back(8'hA5);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_data", 32'(out_data), 32'hA5);
    check("t1_level", 32'(fifo_level), 32'd1);
    drain("t1");
    check("t1_data_zero", 32'(out_data), 32'h00);

    // 2: long ready interval yields one entry.
    rx_data       = 8'h55;
    rx_data_ready = 1'b1;
    for (int i = 0; i < 300; i++) step();
    rx_data_ready = 1'b0;
    exp_q.push_back(8'h55);
    check("t2_level", 32'(fifo_level), 32'd1);
    step();
    check("t2_level_after", 32'(fifo_level), 32'd1);
    drain("t2");

    // 3: fill, overflow on ninth byte.
    for (int i = 1; i <= 8; i++) push_byte(8'(i), 1'b1);
    check("t3_level_full", 32'(fifo_level), 32'd8);
    check("t3_ovf_before", 32'(overflow), 32'd0);
    push_byte(8'h09, 1'b0);
    check("t3_ovf", 32'(overflow), 32'd1);
    check("t3_level", 32'(fifo_level), 32'd8);

    // 5: set wins over clear; clear alone then clears.
    rx_data        = 8'hEE;
    rx_data_ready  = 1'b1;
    clear_overflow = 1'b1;
    step();
    rx_data_ready  = 1'b0;
    clear_overflow = 1'b0;
    check("t5_ovf_kept", 32'(overflow), 32'd1);
    check("t5_level", 32'(fifo_level), 32'd8);
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    check("t5_ovf_cleared", 32'(overflow), 32'd0);

    // 4: push into full FIFO with simultaneous pop.
    begin
      logic [7:0] e;
      e = exp_q.pop_front();
      check("t4_head", 32'(out_data), 32'(e));
    end
    rx_data       = 8'hFF;
    rx_data_ready = 1'b1;
    out_ready     = 1'b1;
    step();
    rx_data_ready = 1'b0;
    out_ready     = 1'b0;
    exp_q.push_back(8'hFF);
    check("t4_level", 32'(fifo_level), 32'd8);
    check("t4_ovf", 32'(overflow), 32'd0);
    step();
    drain("t34");

    // 6: asynchronous reset mid-stream discards data.
    push_byte(8'h11, 1'b1);
    push_byte(8'h22, 1'b1);
    push_byte(8'h33, 1'b1);
    check("t6_level_pre", 32'(fifo_level), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_level", 32'(fifo_level), 32'd0);
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_data", 32'(out_data), 32'h00);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    step();
    push_byte(8'h97, 1'b1);
    check("t6_level_post", 32'(fifo_level), 32'd1);
    drain("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
